l2_cache: RTL and testbench

- Unified, set-associative, write-through, write-allocate L2 cache between an L1 controller and main memory.
- Transfers are whole blocks on both sides; addresses are block addresses, so there are no offset bits.
- Read misses fetch from memory with a ready handshake. Writes are posted to memory with no handshake.

---
 rtl/l2_cache_pkg.sv | 22 ++
 rtl/l2_tag_lookup.sv | 38 +++
 rtl/l2_cache.sv | 202 ++++++++++++++++++++
 tb/tb_l2_cache.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared types and default geometry for the L2 cache.
// Derived localparams describe the default configuration.
package l2_cache_pkg;

    localparam int L2_DATA_WIDTH = 32;
    localparam int L2_ADDR_WIDTH = 11;
    localparam int L2_CACHE_SIZE = 512;
    localparam int L2_BLOCK_SIZE = 32;
    localparam int L2_NUM_WAYS   = 4;

    localparam int NUM_SETS = L2_CACHE_SIZE / (L2_BLOCK_SIZE * L2_NUM_WAYS);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = L2_ADDR_WIDTH - INDEX_W;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    typedef logic [L2_BLOCK_SIZE-1:0][L2_DATA_WIDTH-1:0] block_t;

endpackage

// File: rtl/l2_tag_lookup.sv
// Combinational tag compare across one set, plus victim choice:
// lowest invalid way first, otherwise the set's round-robin pointer.
module l2_tag_lookup
    import l2_cache_pkg::*;
#(
    parameter int NUM_WAYS = L2_NUM_WAYS,
    parameter int TAG_BITS = TAG_W,
    localparam int WAY_W   = $clog2(NUM_WAYS)
) (
    input  logic [TAG_BITS-1:0]               tag,
    input  logic [NUM_WAYS-1:0]               way_valid,
    input  logic [NUM_WAYS-1:0][TAG_BITS-1:0] way_tag,
    input  logic [WAY_W-1:0]                  rr_ptr,
    output logic                              hit,
    output logic [WAY_W-1:0]                  hit_way,
    output logic [WAY_W-1:0]                  victim_way,
    output logic                              victim_is_ptr
);

    // Descending scan so the lowest-numbered match / invalid way wins.
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        victim_way    = rr_ptr;
        victim_is_ptr = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_valid[w] && (way_tag[w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!way_valid[w]) begin
                victim_way    = WAY_W'(w);
                victim_is_ptr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/l2_cache.sv
// Set-associative, write-through, write-allocate L2 cache with block-wide
// transfers. Read misses stall in MISS until memory answers with mem_ready.
module l2_cache
    import l2_cache_pkg::*;
#(
    parameter int DATA_WIDTH = L2_DATA_WIDTH,
    parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
    parameter int CACHE_SIZE = L2_CACHE_SIZE,
    parameter int BLOCK_SIZE = L2_BLOCK_SIZE,
    parameter int NUM_WAYS   = L2_NUM_WAYS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_WIDTH-1:0]                l1_cache_addr,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l1_cache_data_in,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l1_block_data_out,
    output logic                                 l1_block_valid,
    input  logic                                 l1_cache_read,
    input  logic                                 l1_cache_write,
    output logic                                 l1_cache_ready,
    output logic                                 l1_cache_hit,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
    input  logic                                 mem_ready,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
    output logic                                 mem_read,
    output logic                                 mem_write
);

    localparam int N_SETS = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
    localparam int IDX_W  = $clog2(N_SETS);
    localparam int TG_W   = ADDR_WIDTH - IDX_W;
    localparam int WAY_W  = $clog2(NUM_WAYS);

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

    logic [NUM_WAYS-1:0]            line_valid_q [N_SETS];
    logic [NUM_WAYS-1:0][TG_W-1:0]  line_tag_q   [N_SETS];
    logic [WAY_W-1:0]               ptr_q        [N_SETS];
    blk_t                           data_mem     [N_SETS][NUM_WAYS];

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  blk_valid_q, blk_valid_d;
    logic                  hit_q, hit_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    blk_t                  rdata_q, rdata_d;
    blk_t                  wdata_q, wdata_d;

    logic [ADDR_WIDTH-1:0] lk_addr;
    logic [IDX_W-1:0]      lk_idx;
    logic [TG_W-1:0]       lk_tag;
    logic                  lk_hit, vict_from_ptr;
    logic [WAY_W-1:0]      lk_hit_way, vict_way;

    logic                  inst_en, ptr_adv;
    logic [WAY_W-1:0]      inst_way;
    blk_t                  inst_data;

    // While waiting on a fill, the lookup targets the latched miss address.
    assign lk_addr = (state_q == MISS) ? miss_addr_q : l1_cache_addr;
    assign lk_idx  = lk_addr[IDX_W-1:0];
    assign lk_tag  = lk_addr[ADDR_WIDTH-1:IDX_W];

    l2_tag_lookup #(
        .NUM_WAYS (NUM_WAYS),
        .TAG_BITS (TG_W)
    ) u_lookup (
        .tag           (lk_tag),
        .way_valid     (line_valid_q[lk_idx]),
        .way_tag       (line_tag_q[lk_idx]),
        .rr_ptr        (ptr_q[lk_idx]),
        .hit           (lk_hit),
        .hit_way       (lk_hit_way),
        .victim_way    (vict_way),
        .victim_is_ptr (vict_from_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            blk_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            miss_addr_q <= '0;
            rdata_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            blk_valid_q <= blk_valid_d;
            hit_q       <= hit_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            miss_addr_q <= miss_addr_d;
            rdata_q     <= rdata_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (l1_cache_read && !lk_hit) state_d = MISS;
            MISS:    if (mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs hold until the next accepted request; a dual read/write takes the read.
    always_comb begin
        ready_d     = ready_q;
        blk_valid_d = blk_valid_q;
        hit_d       = hit_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        miss_addr_d = miss_addr_q;
        rdata_d     = rdata_q;
        wdata_d     = wdata_q;
        inst_en     = 1'b0;
        inst_way    = vict_way;
        inst_data   = l1_cache_data_in;
        ptr_adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (l1_cache_read) begin
                    mem_write_d = 1'b0;
                    hit_d       = lk_hit;
                    blk_valid_d = lk_hit;
                    if (lk_hit) begin
                        rdata_d = data_mem[lk_idx][lk_hit_way];
                    end else begin
                        mem_read_d  = 1'b1;
                        mem_addr_d  = l1_cache_addr;
                        miss_addr_d = l1_cache_addr;
                        ready_d     = 1'b0;
                    end
                end else if (l1_cache_write) begin
                    inst_en     = 1'b1;
                    inst_way    = lk_hit ? lk_hit_way : vict_way;
                    ptr_adv     = !lk_hit && vict_from_ptr;
                    hit_d       = lk_hit;
                    blk_valid_d = 1'b0;
                    mem_write_d = 1'b1;
                    mem_addr_d  = l1_cache_addr;
                    wdata_d     = l1_cache_data_in;
                    ready_d     = 1'b1;
                end
            end
            MISS: begin
                if (mem_ready) begin
                    inst_en     = 1'b1;
                    inst_data   = mem_data_block;
                    ptr_adv     = vict_from_ptr;
                    rdata_d     = mem_data_block;
                    blk_valid_d = 1'b1;
                    hit_d       = 1'b0;
                    mem_read_d  = 1'b0;
                    ready_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SETS; s++) begin
                line_valid_q[s] <= '0;
                line_tag_q[s]   <= '0;
                ptr_q[s]        <= '0;
            end
        end else if (inst_en) begin
            line_valid_q[lk_idx][inst_way] <= 1'b1;
            line_tag_q[lk_idx][inst_way]   <= lk_tag;
            if (ptr_adv) ptr_q[lk_idx] <= ptr_q[lk_idx] + WAY_W'(1);
        end
    end

    // Block storage needs no reset: a line is only visible through its valid bit.
    always_ff @(posedge clk) begin
        if (inst_en) data_mem[lk_idx][inst_way] <= inst_data;
    end

    assign l1_cache_ready    = ready_q;
    assign l1_block_valid    = blk_valid_q;
    assign l1_cache_hit      = hit_q;
    assign l1_block_data_out = rdata_q;
    assign mem_read          = mem_read_q;
    assign mem_write         = mem_write_q;
    assign mem_addr          = mem_addr_q;
    assign mem_data_out      = wdata_q;

endmodule

// File: tb/tb_l2_cache.sv
// Bench for l2_cache: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural cache model.
module tb_l2_cache;
    import l2_cache_pkg::*;

    localparam int S = NUM_SETS;
    localparam int W = L2_NUM_WAYS;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [L2_ADDR_WIDTH-1:0] addr = '0;
    block_t                   din = '0, dout, mblk = '0, mout;
    logic                     blk_valid, rd = 1'b0, wr = 1'b0, ready, hit;
    logic                     mready = 1'b0, mread, mwrite;
    logic [L2_ADDR_WIDTH-1:0] maddr;

    always #5 clk = ~clk;

    l2_cache dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .l1_cache_addr     (addr),
        .l1_cache_data_in  (din),
        .l1_block_data_out (dout),
        .l1_block_valid    (blk_valid),
        .l1_cache_read     (rd),
        .l1_cache_write    (wr),
        .l1_cache_ready    (ready),
        .l1_cache_hit      (hit),
        .mem_data_block    (mblk),
        .mem_ready         (mready),
        .mem_addr          (maddr),
        .mem_data_out      (mout),
        .mem_read          (mread),
        .mem_write         (mwrite)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Behavioural model: cache contents plus the outputs the spec requires.
    bit     m_v   [S][W];
    int     m_tag [S][W];
    block_t m_d   [S][W];
    int     m_ptr [S];
    bit     m_miss = 1'b0;
    int     m_addr = 0;
    bit     e_ready = 1'b1, e_valid = 1'b0, e_hit = 1'b0, e_mread = 1'b0, e_mwrite = 1'b0;
    int     e_maddr = 0;
    block_t e_rdata = '0, e_wdata = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_blk(input string nm, input block_t act, input block_t exp);
        int bad;
        bad = -1;
        n_chk++;
        for (int i = L2_BLOCK_SIZE - 1; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: word %0d got %h expected %h (t=%0t)", nm, bad, act[bad], exp[bad], $time);
        end
    endtask

    function automatic block_t pat(input logic [31:0] base);
        block_t p;
        for (int i = 0; i < L2_BLOCK_SIZE; i++) p[i] = base ^ 32'(i);
        return p;
    endfunction

    function automatic block_t rand_blk();
        block_t p;
        for (int i = 0; i < L2_BLOCK_SIZE; i++) p[i] = $urandom;
        return p;
    endfunction

    function automatic int find(input int a);
        for (int w = 0; w < W; w++)
            if (m_v[a % S][w] && m_tag[a % S][w] == a / S) return w;
        return -1;
    endfunction

    function automatic int alloc(input int s);
        int r;
        for (int w = 0; w < W; w++) if (!m_v[s][w]) return w;
        r = m_ptr[s];
        m_ptr[s] = (r + 1) % W;
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < S; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < W; w++) m_v[s][w] = 1'b0;
        end
        m_miss = 1'b0;
        e_ready = 1'b1; e_valid = 1'b0; e_hit = 1'b0; e_mread = 1'b0; e_mwrite = 1'b0;
        e_maddr = 0; e_rdata = '0; e_wdata = '0;
    endtask

    task automatic model_edge();
        int a, s, w;
        a = int'(addr);
        s = a % S;
        if (!m_miss) begin
            if (rd) begin
                w = find(a);
                e_mwrite = 1'b0;
                if (w >= 0) begin
                    e_rdata = m_d[s][w]; e_valid = 1'b1; e_hit = 1'b1;
                end else begin
                    m_miss = 1'b1; m_addr = a;
                    e_mread = 1'b1; e_maddr = a; e_ready = 1'b0; e_valid = 1'b0; e_hit = 1'b0;
                end
            end else if (wr) begin
                w = find(a);
                e_hit = (w >= 0);
                if (w < 0) w = alloc(s);
                m_v[s][w] = 1'b1; m_tag[s][w] = a / S; m_d[s][w] = din;
                e_mwrite = 1'b1; e_maddr = a; e_wdata = din; e_valid = 1'b0; e_ready = 1'b1;
            end
        end else if (mready) begin
            s = m_addr % S;
            w = alloc(s);
            m_v[s][w] = 1'b1; m_tag[s][w] = m_addr / S; m_d[s][w] = mblk;
            e_rdata = mblk; e_valid = 1'b1; e_hit = 1'b0; e_mread = 1'b0; e_ready = 1'b1;
            m_miss = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("ready", ready, e_ready);
                chk("blk_valid", blk_valid, e_valid);
                chk("hit", hit, e_hit);
                chk("mem_read", mread, e_mread);
                chk("mem_write", mwrite, e_mwrite);
                chk("mem_addr", maddr, e_maddr);
                chk_blk("l1_data_out", dout, e_rdata);
                chk_blk("mem_data_out", mout, e_wdata);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_fill(input block_t b);
        if (m_miss) begin
            mblk = b; mready = 1'b1;
            tick();
            mready = 1'b0;
        end
    endtask

    task automatic read_fill(input int a);
        addr = 11'(a); rd = 1'b1;
        tick();
        rd = 1'b0;
        finish_fill(rand_blk());
    endtask

    initial begin
        int tags[8] = '{0, 1, 2, 3, 4, 5, 511, 256};
        int miss_cnt;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("reset ready", ready, 1);
        chk("reset mem_read", mread, 0);
        chk("reset blk_valid", blk_valid, 0);
        rst_n = 1'b1;

        // Read-miss allocate
        addr = 11'h00A; rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t1 mem_read", mread, 1);
        chk("t1 mem_addr", maddr, 11'h00A);
        chk("t1 ready", ready, 0);
        mblk = pat(32'hDEADBEEF); mready = 1'b1;
        tick();
        mready = 1'b0;
        chk("t1 valid", blk_valid, 1);
        chk("t1 ready after fill", ready, 1);
        chk("t1 hit", hit, 0);
        chk("t1 data0", dout[0], 32'hDEADBEEF);

        // Read hit
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t2 valid", blk_valid, 1);
        chk("t2 hit", hit, 1);
        chk("t2 data0", dout[0], 32'hDEADBEEF);
        chk("t2 data31", dout[31], 32'hDEADBEF0);
        chk("t2 mem_read", mread, 0);

        // Write miss, posted to memory
        addr = 11'h014; din = pat(32'hA5A5A5A5); wr = 1'b1;
        tick();
        wr = 1'b0;
        chk("t3 mem_write", mwrite, 1);
        chk("t3 mem_addr", maddr, 11'h014);
        chk("t3 mem_data0", mout[0], 32'hA5A5A5A5);
        chk("t3 hit", hit, 0);
        tick();
        chk("t3 mem_write held", mwrite, 1);

        // Write hit then read back
        din = pat(32'h5A5A5A5A); wr = 1'b1;
        tick();
        wr = 1'b0;
        chk("t4 mem_write", mwrite, 1);
        chk("t4 hit", hit, 1);
        chk("t4 ready", ready, 1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t4 read hit", hit, 1);
        chk("t4 read data0", dout[0], 32'h5A5A5A5A);

        // Eviction in set 2
        read_fill(11'h00A);
        read_fill(11'h00E);
        read_fill(11'h012);
        read_fill(11'h016);
        read_fill(11'h01A);
        addr = 11'h00E; rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t5 0x00E hit", hit, 1);
        addr = 11'h00A; rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t5 0x00A evicted", hit, 0);
        chk("t5 0x00A refetch", mread, 1);
        finish_fill(rand_blk());

        // Reset in the middle of a miss
        addr = 11'h01E; rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t6 in miss", ready, 0);
        rst_n = 1'b0;
        #1;
        chk("t6 reset ready", ready, 1);
        chk("t6 reset mem_read", mread, 0);
        tick();
        rst_n = 1'b1;
        addr = 11'h00A; rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t6 post-reset miss", hit, 0);
        chk("t6 post-reset mem_read", mread, 1);
        finish_fill(rand_blk());

        // Simultaneous read and write: read wins
        addr = 11'h00A; din = pat(32'h11111111); wr = 1'b1;
        tick();
        din = pat(32'h22222222); rd = 1'b1;
        tick();
        rd = 1'b0; wr = 1'b0;
        chk("t6 rw mem_write", mwrite, 0);
        chk("t6 rw hit", hit, 1);
        chk("t6 rw data0", dout[0], 32'h11111111);

        // Random traffic
        miss_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            rd = ($urandom % 3 == 0);
            wr = ($urandom % 4 == 0);
            addr = 11'(tags[$urandom % 8] * S + int'($urandom % S));
            din = rand_blk();
            mblk = rand_blk();
            if (m_miss) begin
                mready = (miss_cnt >= 3) || ($urandom % 3 == 0);
                miss_cnt++;
            end else begin
                mready = ($urandom % 8 == 0);
                miss_cnt = 0;
            end
            rst_n = ($urandom % 600 != 0);
            tick();
        end
        rd = 1'b0; wr = 1'b0; mready = 1'b0; rst_n = 1'b1;
        tick();
        tick();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
